ides_word_align: RTL



---
 rtl/ides_word_align_if.sv | 42 ++++
 rtl/ides_word_align.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/ides_word_align_if.sv
// ----------------------------------------------------------------------------
// ides_word_align_if
// Groups the word-aligner signals into one bundle between the link side and
// the aligner.
//   master : drives q, cal, train_en; observes the aligner outputs
//   slave  : the aligner itself
// Signals:
//   q         deserialized word from the IDES
//   cal       delay-calibration-done flag from the calibrator
//   train_en  link is sending the training word
//   bitslip   one-cycle pulse to the IDES bitslip input
//   recal_req one-cycle pulse to the calibrator's recal
//   aligned   word lock achieved
//   data_out  aligned data
//   data_vld  data_out valid
//   slip_cnt  bitslips issued since the last IDLE
//   err       sticky, retries exhausted
// ----------------------------------------------------------------------------
interface ides_word_align_if #(
  parameter int FW = 8
);
  logic [FW-1:0] q;
  logic          cal;
  logic          train_en;
  logic          bitslip;
  logic          recal_req;
  logic          aligned;
  logic [FW-1:0] data_out;
  logic          data_vld;
  logic [3:0]    slip_cnt;
  logic          err;

  modport master (
    output q, cal, train_en,
    input  bitslip, recal_req, aligned, data_out, data_vld, slip_cnt, err
  );

  modport slave (
    input  q, cal, train_en,
    output bitslip, recal_req, aligned, data_out, data_vld, slip_cnt, err
  );
endinterface

// File: rtl/ides_word_align.sv
// ----------------------------------------------------------------------------
// ides_word_align
// Word-alignment stage behind the IDES delay calibrator. After calibration it
// hunts for the training word by pulsing bitslip, forwards aligned data once
// locked, and asks the calibrator to redo the delay when every slip position
// has failed.
// Ports:
//   pclk  module clock (same as the calibrator)
//   rst   synchronous, active-high reset
//   bus   ides_word_align_if.slave (q, cal, train_en in; bitslip, recal_req,
//         aligned, data_out, data_vld, slip_cnt, err out)
//
// state      | meaning
// -----------+-----------------------------------------------------------
// IDLE       | waiting for cal, all outputs low
// CHECK      | counting consecutive q_r == TRAIN matches
// SLIP       | bitslip pulse for this cycle
// SETTLE     | let the IDES settle after a slip
// LOCKED     | aligned, forwarding data, watching for loss of lock
// FAIL       | recal_req pulse for this cycle, bump the retry count
// WAIT_DROP  | waiting for the calibrator to drop cal
// ----------------------------------------------------------------------------
module ides_word_align #(
  parameter int            FW         = 8,
  parameter logic [FW-1:0] TRAIN      = 8'hA5,
  parameter int            SETTLE_CYC = 4,
  parameter int            LOCK_CNT   = 16,
  parameter int            ERR_LIM    = 4,
  parameter int            MAX_RETRY  = 3
) (
  input logic               pclk,
  input logic               rst,
  ides_word_align_if.slave  bus
);

  localparam logic [7:0] LOCK_LAST   = 8'(LOCK_CNT - 1);
  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYC - 1);
  localparam logic [3:0] ERR_LAST    = 4'(ERR_LIM - 1);
  localparam logic [3:0] SLIP_LAST   = 4'(FW - 1);
  localparam logic [3:0] RETRY_MAX   = 4'(MAX_RETRY);
  // 255 cycles in WAIT_DROP with cal still high before failing again
  localparam logic [7:0] DROP_LAST   = 8'd254;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_SLIP,
    S_SETTLE,
    S_LOCKED,
    S_FAIL,
    S_WAIT_DROP
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [FW-1:0] r_q;
  logic [FW-1:0] r_data;
  logic [7:0]    r_match_cnt, w_match_cnt_nxt;
  logic [7:0]    r_wait_cnt,  w_wait_cnt_nxt;
  logic [3:0]    r_mis_cnt,   w_mis_cnt_nxt;
  logic [3:0]    r_slip_cnt,  w_slip_cnt_nxt;
  logic [3:0]    r_retry_cnt, w_retry_cnt_nxt;
  logic          r_err,       w_err_nxt;
  logic          r_bitslip;
  logic          r_recal;
  logic          r_aligned;

  logic          w_match;
  logic          w_force_idle;
  logic [3:0]    w_retry_inc;
  logic [3:0]    w_slip_inc;

  assign w_match      = (r_q == TRAIN);
  // losing calibration overrides everything except where cal=0 is expected
  assign w_force_idle = !bus.cal && (r_state != S_IDLE) && (r_state != S_WAIT_DROP);
  assign w_retry_inc  = (r_retry_cnt == 4'hF) ? 4'hF : r_retry_cnt + 4'd1;
  assign w_slip_inc   = (r_slip_cnt == 4'hF) ? 4'hF : r_slip_cnt + 4'd1;

  always_ff @(posedge pclk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_match_cnt_nxt = r_match_cnt;
    w_wait_cnt_nxt  = r_wait_cnt;
    w_mis_cnt_nxt   = r_mis_cnt;
    w_slip_cnt_nxt  = r_slip_cnt;
    w_retry_cnt_nxt = r_retry_cnt;
    w_err_nxt       = r_err;

    // the recal pulse is already out while in FAIL, so count it even if
    // cal drops in the same cycle
    if (r_state == S_LOCKED) begin
      w_retry_cnt_nxt = 4'd0;
    end
    if (r_state == S_FAIL) begin
      w_retry_cnt_nxt = w_retry_inc;
      if (w_retry_inc >= RETRY_MAX) begin
        w_err_nxt = 1'b1;
      end
    end

    if (w_force_idle) begin
      w_state_nxt     = S_IDLE;
      w_slip_cnt_nxt  = 4'd0;
      w_match_cnt_nxt = 8'd0;
      w_mis_cnt_nxt   = 4'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_slip_cnt_nxt  = 4'd0;
          w_match_cnt_nxt = 8'd0;
          w_mis_cnt_nxt   = 4'd0;
          if (bus.cal) begin
            w_state_nxt = S_CHECK;
          end
        end
        S_CHECK: begin
          if (w_match) begin
            if (r_match_cnt == LOCK_LAST) begin
              w_state_nxt     = S_LOCKED;
              w_match_cnt_nxt = 8'd0;
              w_mis_cnt_nxt   = 4'd0;
            end else begin
              w_match_cnt_nxt = r_match_cnt + 8'd1;
            end
          end else begin
            w_match_cnt_nxt = 8'd0;
            // every rotation has been tried; no extra slip on the last miss
            w_state_nxt = (r_slip_cnt == SLIP_LAST) ? S_FAIL : S_SLIP;
          end
        end
        S_SLIP: begin
          w_slip_cnt_nxt = w_slip_inc;
          w_wait_cnt_nxt = 8'd0;
          w_state_nxt    = S_SETTLE;
        end
        S_SETTLE: begin
          if (r_wait_cnt == SETTLE_LAST) begin
            w_state_nxt     = S_CHECK;
            w_match_cnt_nxt = 8'd0;
          end else begin
            w_wait_cnt_nxt = r_wait_cnt + 8'd1;
          end
        end
        S_LOCKED: begin
          if (bus.train_en && !w_match) begin
            if (r_mis_cnt == ERR_LAST) begin
              w_state_nxt     = S_CHECK;
              w_mis_cnt_nxt   = 4'd0;
              w_match_cnt_nxt = 8'd0;
            end else begin
              w_mis_cnt_nxt = r_mis_cnt + 4'd1;
            end
          end else begin
            w_mis_cnt_nxt = 4'd0;
          end
        end
        S_FAIL: begin
          w_state_nxt    = S_WAIT_DROP;
          w_wait_cnt_nxt = 8'd0;
        end
        S_WAIT_DROP: begin
          if (!bus.cal) begin
            w_state_nxt    = S_IDLE;
            w_slip_cnt_nxt = 4'd0;
          end else if (r_wait_cnt == DROP_LAST) begin
            w_state_nxt = S_FAIL;
          end else begin
            w_wait_cnt_nxt = r_wait_cnt + 8'd1;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  // Outputs are registered from the next state so pulses are glitch-free
  // and data_out/data_vld line up on the same edge.
  always_ff @(posedge pclk) begin
    if (rst) begin
      r_q         <= '0;
      r_data      <= '0;
      r_match_cnt <= 8'd0;
      r_wait_cnt  <= 8'd0;
      r_mis_cnt   <= 4'd0;
      r_slip_cnt  <= 4'd0;
      r_retry_cnt <= 4'd0;
      r_err       <= 1'b0;
      r_bitslip   <= 1'b0;
      r_recal     <= 1'b0;
      r_aligned   <= 1'b0;
    end else begin
      r_q         <= bus.q;
      r_data      <= (w_state_nxt == S_LOCKED) ? r_q : '0;
      r_match_cnt <= w_match_cnt_nxt;
      r_wait_cnt  <= w_wait_cnt_nxt;
      r_mis_cnt   <= w_mis_cnt_nxt;
      r_slip_cnt  <= w_slip_cnt_nxt;
      r_retry_cnt <= w_retry_cnt_nxt;
      r_err       <= w_err_nxt;
      r_bitslip   <= (w_state_nxt == S_SLIP);
      r_recal     <= (w_state_nxt == S_FAIL);
      r_aligned   <= (w_state_nxt == S_LOCKED);
    end
  end

  assign bus.bitslip   = r_bitslip;
  assign bus.recal_req = r_recal;
  assign bus.aligned   = r_aligned;
  assign bus.data_vld  = r_aligned;
  assign bus.data_out  = r_data;
  assign bus.slip_cnt  = r_slip_cnt;
  assign bus.err       = r_err;

endmodule
